muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in operand width and multiply step size. Sits beside the ALU in the execute stage. The decode controller raises `start` with the instruction's funct3 when `aluop` selects an M-extension op. The execute stage stalls the pipeline while `busy` is high and captures `result` when `done` pulses. It adds multi-cycle sequencing, a start/done handshake, pipeline flush abort, and RISC-V divide corner-case handling to the single-cycle ALU path.

## Interface
- `XLEN`, default 32, operand and result width.
- `MUL_STEP`, default 4, multiplier bits retired per cycle. Must divide `XLEN`.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a new operation; sampled only when `busy`=0.
- `flush`  in  1  abort any in-flight operation; priority over `start`.
- `funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  XLEN  rs1 operand; captured with `start`.
- `b`  in  XLEN  rs2 operand; captured with `start`.
- `busy`  out  1  high from the cycle after an accepted start through the `done` cycle, inclusive.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  registered; holds its value until the next `done`.

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE with `start` (and no `flush`): latch funct3, operand magnitudes and sign flags, then branch:
  - Divisor is 0 (any div/rem op): go to DONE directly.
    - DIV/DIVU result = all ones.
    - REM/REMU result = `a`.
  - DIV with `a`=−2^(XLEN−1) and `b`=−1: go to DONE directly.
    - DIV result = `a`.
    - REM result = 0.
  - Other multiply ops: go to MUL. Other divide ops: go to DIV.
- MUL: shift-add on magnitudes into a 2·XLEN product, `MUL_STEP` bits per cycle, XLEN/MUL_STEP cycles, counter-driven.
  - Signedness: MUL/MULH treat both operands as signed. MULHSU treats `a` as signed and `b` as unsigned. MULHU treats both as unsigned.
- DIV: restoring division on magnitudes, 1 quotient bit per cycle, XLEN cycles.
- FIX: one cycle that applies sign correction, then go to DONE.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- DONE: `done`=1 and `result` is updated, then go to IDLE.
- `start` while `busy`=1: ignored, no queuing.
- `flush` in any state: go to IDLE next cycle.
  - No `done` is issued for the aborted op; `result` is unchanged.
  - A `start` in the same cycle as `flush` is dropped.
- `start` in the `done` cycle: ignored, because the FSM is not in IDLE. The earliest restart is the cycle after `done`.
- All arithmetic is carried out at XLEN+1 or 2·XLEN width internally; no truncation before FIX.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, iteration counter 0.
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Multiply, with N = XLEN/MUL_STEP:
  - MUL occupies cycles 1..N, FIX is cycle N+1, `done` is in cycle N+2.
  - Default latency is 10 cycles.
- Divide:
  - DIV occupies cycles 1..XLEN, FIX is cycle XLEN+1, `done` is in cycle XLEN+2.
  - Default latency is 34 cycles.
- Corner cases (divide by zero, overflow): `done` in cycle 1, `busy` high for cycle 1 only.
- `reset` mid-operation behaves as `flush` and also clears `result`.

## Structure
- Shared package `muldiv_pkg` holds:
  - `funct3` localparams (MUL..REMU).
  - State enum `muldiv_state_t`.
  - Helper constant for the most-negative XLEN value.
- The decode controller imports the same funct3 constants.
- Single module with no sub-modules. Counter width is $clog2(XLEN)+1.

## Test plan
- MUL `a`=7, `b`=0xFFFFFFFD (−3) → `result`=0xFFFFFFEB, `done` in cycle 10, `busy` high cycles 1–10.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Each has `done` in cycle 34.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0. Each has `done` in cycle 1.
- Start DIV, assert `flush` in cycle 5 together with a new `start` → `busy`=0 in cycle 6, no `done`, `result` unchanged, and the new start is not accepted.
- `start` pulsed during `busy` and in the `done` cycle → ignored. Re-run with XLEN=16, MUL_STEP=2: MUL 300×−2 → 0xFDA8 with `done` in cycle 10.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// The decode controller imports the same funct3 encodings.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

    // Most-negative value for any width up to 64: take the top XLEN bits.
    localparam logic [63:0] MOST_NEG_64 = 64'h8000_0000_0000_0000;

    function automatic logic op_a_signed(input logic [2:0] f3);
        return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide beside the ALU: shift-add multiply, restoring
// divide, sign fix-up cycle, start/done handshake and flush abort.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW     = $clog2(XLEN) + 1;
    localparam int N_MUL  = XLEN / MUL_STEP;
    localparam logic [CW-1:0] MUL_LAST = CW'(N_MUL - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = MOST_NEG_64[63 -: XLEN];
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    muldiv_state_t     state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [2:0]        op_reg, op_next;
    logic              neg_res_reg, neg_res_next;
    logic              neg_a_reg, neg_a_next;
    logic [2*XLEN-1:0] prod_reg, prod_next;
    logic [2*XLEN-1:0] mcand_reg, mcand_next;
    logic [XLEN-1:0]   mplr_reg, mplr_next;
    logic [XLEN:0]     rem_reg, rem_next;
    logic [XLEN-1:0]   quo_reg, quo_next;
    logic [XLEN-1:0]   dvsr_reg, dvsr_next;
    logic [XLEN-1:0]   result_reg, result_next;

    // Operand decode for the accept cycle
    logic            a_sgn, b_sgn, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_sgn   = op_a_signed(funct3) & a[XLEN-1];
    assign b_sgn   = op_b_signed(funct3) & b[XLEN-1];
    assign a_mag   = a_sgn ? -a : a;
    assign b_mag   = b_sgn ? -b : b;
    assign div_ovf = !funct3[0] && (a == MOST_NEG) && (b == ALL_ONES);

    // One multiplier digit of MUL_STEP bits: sum of shifted partial products
    logic [2*XLEN-1:0] pp [MUL_STEP];
    logic [2*XLEN-1:0] step_sum;

    for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
        assign pp[gi] = mplr_reg[gi] ? (mcand_reg << gi) : '0;
    end

    always_comb begin
        step_sum = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            step_sum = step_sum + pp[i];
        end
    end

    // Restoring divide step; remainder carried at XLEN+1, difference at XLEN+2
    logic [XLEN:0]   rem_shift;
    logic [XLEN+1:0] rem_diff;
    logic            sub_ok;

    assign rem_shift = (rem_reg << 1) | {{XLEN{1'b0}}, quo_reg[XLEN-1]};
    assign rem_diff  = {1'b0, rem_shift} - {2'b00, dvsr_reg};
    assign sub_ok    = ~rem_diff[XLEN+1];

    // Sign correction applied in the FIX cycle
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_signed, rem_signed, fix_value;

    assign prod_signed = neg_res_reg ? -prod_reg : prod_reg;
    assign quo_signed  = neg_res_reg ? -quo_reg : quo_reg;
    assign rem_signed  = neg_a_reg ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];

    always_comb begin
        fix_value = rem_signed;
        case (op_reg)
            F3_MUL:                        fix_value = prod_signed[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_value = prod_signed[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fix_value = quo_signed;
            default:                       fix_value = rem_signed;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        op_next      = op_reg;
        neg_res_next = neg_res_reg;
        neg_a_next   = neg_a_reg;
        prod_next    = prod_reg;
        mcand_next   = mcand_reg;
        mplr_next    = mplr_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        dvsr_next    = dvsr_reg;
        result_next  = result_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    op_next      = funct3;
                    neg_res_next = a_sgn ^ b_sgn;
                    neg_a_next   = a_sgn;
                    cnt_next     = '0;
                    if (funct3[2]) begin
                        if (b == '0) begin
                            state_next  = ST_DONE;
                            result_next = funct3[1] ? a : ALL_ONES;
                        end else if (div_ovf) begin
                            state_next  = ST_DONE;
                            result_next = funct3[1] ? '0 : a;
                        end else begin
                            state_next = ST_DIV;
                            rem_next   = '0;
                            quo_next   = a_mag;
                            dvsr_next  = b_mag;
                        end
                    end else begin
                        state_next = ST_MUL;
                        prod_next  = '0;
                        mcand_next = {{XLEN{1'b0}}, a_mag};
                        mplr_next  = b_mag;
                    end
                end
            end
            ST_MUL: begin
                prod_next  = prod_reg + step_sum;
                mcand_next = mcand_reg << MUL_STEP;
                mplr_next  = mplr_reg >> MUL_STEP;
                if (cnt_reg == MUL_LAST) begin
                    state_next = ST_FIX;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_DIV: begin
                rem_next = sub_ok ? rem_diff[XLEN:0] : rem_shift;
                quo_next = {quo_reg[XLEN-2:0], sub_ok};
                if (cnt_reg == DIV_LAST) begin
                    state_next = ST_FIX;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_FIX: begin
                result_next = fix_value;
                state_next  = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // Abort wins over everything; an op retired in FIX is not written back.
        if (flush) begin
            state_next  = ST_IDLE;
            cnt_next    = '0;
            result_next = result_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            op_reg      <= '0;
            neg_res_reg <= 1'b0;
            neg_a_reg   <= 1'b0;
            prod_reg    <= '0;
            mcand_reg   <= '0;
            mplr_reg    <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvsr_reg    <= '0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            op_reg      <= op_next;
            neg_res_reg <= neg_res_next;
            neg_a_reg   <= neg_a_next;
            prod_reg    <= prod_next;
            mcand_reg   <= mcand_next;
            mplr_reg    <= mplr_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            dvsr_reg    <= dvsr_next;
            result_reg  <= result_next;
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign done   = (state_reg == ST_DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed checks of muldiv_unit against an arithmetic
// reference model (XLEN=32/MUL_STEP=4 and XLEN=16/MUL_STEP=2 instances).
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    logic        start16, flush16;
    logic [2:0]  funct3_16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [15:0] result16;

    muldiv_unit #(.XLEN(32), .MUL_STEP(4)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    muldiv_unit #(.XLEN(16), .MUL_STEP(2)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .flush(flush16), .funct3(funct3_16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .result(result16)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference arithmetic: RISC-V M semantics on w-bit operands
    function automatic logic [31:0] ref_res(input int w, input logic [2:0] f3,
                                            input logic [31:0] ai, input logic [31:0] bi);
        longint mask, ua, ub, sa, sb, p, q, r;
        logic [63:0] pu;
        mask = (longint'(1) << w) - 1;
        ua = longint'(ai) & mask;
        ub = longint'(bi) & mask;
        sa = ua;
        sb = ub;
        if (ua[w-1]) sa = ua - (longint'(1) << w);
        if (ub[w-1]) sb = ub - (longint'(1) << w);
        if (!f3[2]) begin
            case (f3)
                F3_MUL, F3_MULH: p = sa * sb;
                F3_MULHSU:       p = sa * ub;
                default:         p = ua * ub;
            endcase
            pu = p;
            if (f3 == F3_MUL) return 32'(pu & 64'(mask));
            return 32'((pu >> w) & 64'(mask));
        end
        if (ub == 0) return f3[1] ? 32'(ua) : 32'(mask);
        if (!f3[0] && sa == -(longint'(1) << (w - 1)) && sb == -1)
            return f3[1] ? 32'd0 : 32'(ua);
        if (!f3[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        return 32'((f3[1] ? r : q) & mask);
    endfunction

    function automatic int lat_of(input int w, input int step, input logic [2:0] f3,
                                  input logic [31:0] ai, input logic [31:0] bi);
        longint mask, ua, ub;
        mask = (longint'(1) << w) - 1;
        ua = longint'(ai) & mask;
        ub = longint'(bi) & mask;
        if (!f3[2]) return w / step + 2;
        if (ub == 0) return 1;
        if (!f3[0] && ua == (longint'(1) << (w - 1)) && ub == mask) return 1;
        return w + 2;
    endfunction

    // Cycle-level expectation for the 32-bit instance
    bit          m_active = 1'b0;
    int          m_k = 0;
    int          m_lat = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_result = '0;
    logic [2:0]  m_f3 = '0;
    logic [31:0] m_a = '0, m_b = '0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_active <= 1'b0;
            m_result <= '0;
        end else if (m_active && m_k == m_lat) begin
            m_result <= m_pend;
            m_active <= 1'b0;
            $display("TXN f3=%0d a=%h b=%h result=%h latency=%0d", m_f3, m_a, m_b, m_pend, m_lat);
        end else if (m_active) begin
            if (flush) m_active <= 1'b0;
            else       m_k <= m_k + 1;
        end else if (start && !flush) begin
            m_active <= 1'b1;
            m_k      <= 1;
            m_lat    <= lat_of(32, 4, funct3, a, b);
            m_pend   <= ref_res(32, funct3, a, b);
            m_f3     <= funct3;
            m_a      <= a;
            m_b      <= b;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_active});
            chk("done", {31'd0, done}, {31'd0, m_active && (m_k == m_lat)});
            chk("result", result, (m_active && m_k == m_lat) ? m_pend : m_result);
        end
    end

    // Directed op on either instance with literal latency and result
    task automatic do_op(input bit sel, input logic [2:0] f3, input logic [31:0] ai,
                         input logic [31:0] bi, input logic [31:0] exp_r, input int exp_lat,
                         input string name);
        int k;
        for (k = 0; k < 100 && (sel ? busy16 : busy); k++) @(negedge clk);
        if (sel) begin
            start16 = 1'b1; funct3_16 = f3; a16 = ai[15:0]; b16 = bi[15:0];
        end else begin
            start = 1'b1; funct3 = f3; a = ai; b = bi;
        end
        @(negedge clk);
        start = 1'b0;
        start16 = 1'b0;
        for (k = 1; k <= 100; k++) begin
            chk({name, " busy"}, {31'd0, sel ? busy16 : busy}, 32'd1);
            if (sel ? done16 : done) break;
            @(negedge clk);
        end
        chk({name, " latency"}, k, exp_lat);
        chk({name, " res"}, sel ? {16'd0, result16} : result, exp_r);
        if (sel) $display("TXN16 f3=%0d a=%h b=%h result=%h latency=%0d", f3, ai[15:0], bi[15:0], result16, k);
        @(negedge clk);
        chk({name, " idle after done"}, {31'd0, sel ? busy16 : busy}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_opnd(input int w);
        logic [31:0] mask;
        mask = 32'((longint'(1) << w) - 1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return mask;
            2:       return 32'(longint'(1) << (w - 1));
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom & mask;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t tbl [12] = '{
        '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 10},
        '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 10},
        '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 10},
        '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 10},
        '{F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1},
        '{F3_REM,    32'd5,          32'd0,         32'd5,         1},
        '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
        '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1},
        '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34},
        '{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34},
        '{F3_DIVU,   32'd100,        32'd7,         32'd14,        34},
        '{F3_REMU,   32'd100,        32'd7,         32'd2,         34}
    };

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; a = '0; b = '0;
        start16 = 1'b0; flush16 = 1'b0; funct3_16 = '0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset result16", {16'd0, result16}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            chk($sformatf("model vec%0d", i), ref_res(32, tbl[i].f3, tbl[i].a, tbl[i].b), tbl[i].r);
            do_op(1'b0, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].lat, $sformatf("vec%0d", i));
        end

        // Flush in cycle 5 of a divide, together with a fresh start
        funct3 = F3_DIV; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1; start = 1'b1; funct3 = F3_MUL; a = 32'd3; b = 32'd3;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush busy cycle6", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            chk("flush no done", {31'd0, done}, 32'd0);
            chk("flush busy stays low", {31'd0, busy}, 32'd0);
            chk("flush result held", result, 32'd2);
            @(negedge clk);
        end

        // Starts during busy and in the done cycle are dropped
        funct3 = F3_MUL; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; funct3 = F3_DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("ign done cycle10", {31'd0, done}, 32'd1);
        chk("ign result", result, 32'hFFFF_FFEB);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign busy cycle11", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("ign busy cycle12", {31'd0, busy}, 32'd0);
        chk("ign done cycle12", {31'd0, done}, 32'd0);

        // Random traffic with occasional flush and reset
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            flush = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 2) == 0);
            funct3 = 3'($urandom_range(0, 7));
            a = rnd_opnd(32);
            b = rnd_opnd(32);
            @(negedge clk);
        end
        reset = 1'b0; flush = 1'b0; start = 1'b0;
        for (int k = 0; k < 50 && busy; k++) @(negedge clk);

        // Narrow instance
        chk("model mul16", ref_res(16, F3_MUL, 32'd300, 32'h0000_FFFE), 32'h0000_FDA8);
        do_op(1'b1, F3_MUL, 32'd300, 32'h0000_FFFE, 32'h0000_FDA8, 10, "mul16");
        for (int i = 0; i < 30; i++) begin
            f3 = 3'($urandom_range(0, 7));
            ra = rnd_opnd(16);
            rb = rnd_opnd(16);
            do_op(1'b1, f3, ra, rb, ref_res(16, f3, ra, rb), lat_of(16, 2, f3, ra, rb),
                  $sformatf("rnd16_%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
